fetch_stage: RTL and testbench



---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/fetch_stage.sv | 106 ++++++++++
 tb/tb_fetch_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: datapath widths, PC increment,
// canonical NOP encoding and the {pc, inst} entry carried from fetch
// to decode.
package riscv_pkg;

    localparam int              XLEN     = 32;
    localparam int              INST_W   = 32;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries between the imem response path
// and decode.
//   clk, rst_n       : clock, synchronous active-low reset
//   push, din        : write an entry
//   pop              : retire the head entry (ignored when empty)
//   flush            : drop every entry; wins over push and pop
//   dout             : head entry, or the last presented entry when empty
//   count/full/empty : occupancy
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    fetch_entry_t  last;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush;

    // Decode must see a stable value even when nothing is queued, so the
    // output falls back to whatever was presented most recently.
    assign dout = empty ? last : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            last   <= '0;
        end else begin
            if (!empty) last <= mem[rd_ptr];
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
                cnt <= cnt + CW'(do_push) - CW'(do_pop);
            end
        end
    end

    // Storage needs no reset; occupancy decides what is valid.  When full,
    // a push only happens together with a pop, so the slot overwritten is
    // the head being retired.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage feeding decode.  Owns the PC, issues in-order
// word requests to instruction memory under a credit limit, tags returned
// words with their PC, buffers them and hands {pc, inst} to decode over
// valid/ready.  A redirect retargets the PC, flushes the buffer and drops
// the responses still owed for the abandoned path.
//   clk, rst_n                 : clock, synchronous active-low reset
//   imem_req_valid/ready/addr  : request channel to instruction memory
//   imem_rsp_valid/data        : in-order responses, no backpressure
//   id_valid/ready, id_pc/inst : entry presented to decode
//   redirect_valid/pc          : taken branch/jump target from execute
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rsp_pc;      // PC of the next response that is kept
    logic [XLEN-1:0] target;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   drop;        // responses still owed to a dead path
    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    logic            credit_ok, issue, push, pop;
    fetch_entry_t    fifo_din, head;

    // Every in-flight request already owns a FIFO slot, so a response can
    // always be accepted without backpressuring memory.
    assign credit_ok = (32'(outstanding) + 32'(fifo_count) < 32'(FIFO_DEPTH)) &&
                       (32'(outstanding) < 32'(MAX_OUTSTANDING));

    assign imem_req_valid = rst_n && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc;
    assign issue          = imem_req_valid && imem_req_ready;
    assign push           = imem_rsp_valid && (drop == '0) && !redirect_valid;
    assign pop            = id_valid && id_ready && !redirect_valid;
    assign target         = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= {RESET_PC[31:2], 2'b00};
            rsp_pc      <= {RESET_PC[31:2], 2'b00};
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + OW'(issue) - OW'(imem_rsp_valid);
            if (redirect_valid) begin
                pc     <= target;
                rsp_pc <= target;
                // Everything still in flight belongs to the old path; a
                // response landing now is discarded directly.
                drop   <= outstanding - OW'(imem_rsp_valid);
            end else begin
                if (issue) pc     <= pc + PC_STEP;
                if (push)  rsp_pc <= rsp_pc + PC_STEP;
                if (imem_rsp_valid && (drop != '0)) drop <= drop - OW'(1);
            end
        end
    end

    assign fifo_din = '{pc: rsp_pc, inst: imem_rsp_data};

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (fifo_din),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign id_valid = !fifo_empty;
    assign id_pc    = head.pc;
    assign id_inst  = head.inst;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop));
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (outstanding == '0)));
    a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        imem_req_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2), .MAX_OUTSTANDING(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Memory image: every address holds a distinct word.
    function automatic logic [31:0] img(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC001_D00D;
    endfunction

    // ---------------- instruction memory model ----------------
    typedef struct {
        logic [31:0] a;
        int          due;   // clock edge at which the response is sampled
    } mreq_t;

    mreq_t q[$];
    int    cyc = 0;
    int    lat_min = 1, lat_max = 1;
    bit    rdy_rand = 0;

    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
            end else begin
                if (imem_rsp_valid) void'(q.pop_front());
                if (imem_req_valid && imem_req_ready) begin
                    mreq_t r;
                    r.a   = imem_req_addr;
                    r.due = cyc + 1 + int'($urandom_range(lat_max, lat_min));
                    q.push_back(r);
                end
            end
            @(posedge clk);
            cyc++;
            #1;
            imem_req_ready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
            if (q.size() > 0 && q[0].due <= cyc + 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = img(q[0].a);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    // Decode must see the architectural PC stream: start at RESET_PC, +4 per
    // accepted entry, jump to the aligned target on redirect.  Requests must
    // follow the same rule per accepted request.
    logic [31:0] exp_pc, exp_req;
    bit          expect_idle = 0, hold_prev = 0;

    initial begin
        exp_pc  = RESET_PC;
        exp_req = RESET_PC;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!rst_n)         chk("req_valid_in_reset", imem_req_valid, 0);
            if (redirect_valid) chk("req_valid_on_redirect", imem_req_valid, 0);
            if (expect_idle)    chk("id_valid_after_flush", id_valid, 0);
            if (hold_prev)      chk("id_valid_held", id_valid, 1);
            if (rst_n && id_valid) begin
                chk("id_pc", id_pc, exp_pc);
                chk("id_inst", id_inst, img(exp_pc));
            end
            if (rst_n && imem_req_valid) chk("req_addr", imem_req_addr, exp_req);

            expect_idle = !rst_n || redirect_valid;
            hold_prev   = rst_n && !redirect_valid && id_valid && !id_ready;
            if (!rst_n) begin
                exp_pc  = RESET_PC;
                exp_req = RESET_PC;
            end else if (redirect_valid) begin
                exp_pc  = {redirect_pc[31:2], 2'b00};
                exp_req = {redirect_pc[31:2], 2'b00};
            end else begin
                if (id_valid && id_ready)             exp_pc  = exp_pc + 32'd4;
                if (imem_req_valid && imem_req_ready) exp_req = exp_req + 32'd4;
            end
        end
    end

    // ---------------- directed sequence ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name);
        bit ok = 0;
        for (int i = 0; i < 30; i++) begin
            if (id_valid) begin
                ok = 1;
                break;
            end
            step();
        end
        chk(name, 32'(ok), 1);
    endtask

    initial begin
        bit found;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state
        repeat (3) step();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_id_inst", id_inst, 0);

        // Release: request 0 issues, shows on decode two edges later
        rst_n = 1'b1;
        #1;
        chk("first_req_valid", imem_req_valid, 1);
        chk("first_req_addr", imem_req_addr, RESET_PC);
        step();
        chk("fill_id_valid_1", id_valid, 0);
        step();
        chk("fill_id_valid_2", id_valid, 1);
        chk("first_id_pc", id_pc, 32'h0);
        chk("first_id_inst", id_inst, img(32'h0));
        step();
        chk("second_id_pc", id_pc, 32'h4);
        repeat (20) step();

        // Decode stall: buffer fills, credits run out
        id_ready = 1'b0;
        repeat (10) step();
        chk("stall_id_valid", id_valid, 1);
        chk("stall_req_valid", imem_req_valid, 0);
        id_ready = 1'b1;
        repeat (10) step();

        // Redirect with two requests in flight
        lat_min = 3;
        lat_max = 3;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (q.size() == 2 && !imem_rsp_valid) found = 1;
        end
        chk("p3_two_outstanding", 32'(found), 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("p3_id_valid_low", id_valid, 0);
        chk("p3_req_addr", imem_req_addr, 32'h100);
        wait_valid("p3_wait_first");
        chk("p3_first_pc", id_pc, 32'h100);
        step();
        wait_valid("p3_wait_second");
        chk("p3_second_pc", id_pc, 32'h104);

        // Redirect coincident with a response and a pop, unaligned target
        lat_min = 1;
        lat_max = 1;
        repeat (5) step();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (imem_rsp_valid && id_valid) found = 1;
            else step();
        end
        chk("p4_rsp_and_pop", 32'(found), 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("p4_req_valid", imem_req_valid, 1);
        chk("p4_req_addr", imem_req_addr, 32'h200);
        chk("p4_id_valid_low", id_valid, 0);
        wait_valid("p4_wait_first");
        chk("p4_first_pc", id_pc, 32'h200);
        repeat (10) step();

        // Random memory ready / latency and decode backpressure
        lat_min  = 1;
        lat_max  = 3;
        rdy_rand = 1;
        for (int i = 0; i < 400; i++) begin
            id_ready = 1'($urandom_range(1, 0));
            step();
        end
        rdy_rand = 0;
        lat_max  = 1;
        id_ready = 1'b1;
        repeat (10) step();

        // Reset mid-stream with a full buffer
        id_ready = 1'b0;
        repeat (8) step();
        chk("p6_full_valid", id_valid, 1);
        chk("p6_full_req_valid", imem_req_valid, 0);
        rst_n = 1'b0;
        step();
        chk("p6_rst_id_valid", id_valid, 0);
        chk("p6_rst_req_valid", imem_req_valid, 0);
        rst_n    = 1'b1;
        id_ready = 1'b1;
        #1;
        chk("p6_restart_req_valid", imem_req_valid, 1);
        chk("p6_restart_addr", imem_req_addr, RESET_PC);
        wait_valid("p6_wait_first");
        chk("p6_restart_pc", id_pc, RESET_PC);
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
